// File: rtl/mem_arbiter_if.sv
// Core fetch/data request ports and the shared memory port, grouped for the arbiter.
// slave = arbiter view; master = core + memory view.
interface mem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          if_ack;

    logic          d_req;
    logic          d_we;
    logic [2:0]    d_size;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [DW-1:0] d_rdata;
    logic          d_ack;

    logic          m_req;
    logic          m_we;
    logic [2:0]    m_size;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [DW-1:0] m_rdata;
    logic          m_ack;

    logic          stall;
    logic [31:0]   busy_cycles;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_size, d_addr, d_wdata, m_rdata, m_ack,
        output if_rdata, if_ack, d_rdata, d_ack,
        output m_req, m_we, m_size, m_addr, m_wdata, stall, busy_cycles
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_size, d_addr, d_wdata, m_rdata, m_ack,
        input  if_rdata, if_ack, d_rdata, d_ack,
        input  m_req, m_we, m_size, m_addr, m_wdata, stall, busy_cycles
    );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one req/ack memory port between fetch and data (data wins); one transaction at a time.
// Request seen in IDLE drives m_req next cycle; completion ack follows m_ack by one cycle.
module mem_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic           clk,
    input  logic           reset,
    mem_arbiter_if.slave   bus
);
    typedef enum logic [2:0] {IDLE, BUSY_I, BUSY_D, RESP_I, RESP_D} state_t;

    state_t        state;
    logic          m_req_q;
    logic          m_we_q;
    logic [2:0]    m_size_q;
    logic [AW-1:0] m_addr_q;
    logic [DW-1:0] m_wdata_q;
    logic          if_ack_q;
    logic          d_ack_q;
    logic [DW-1:0] if_rdata_q;
    logic [DW-1:0] d_rdata_q;
    logic [31:0]   busy_q;
    logic          grant_d;
    logic          grant_i;

    // The requester acked in RESP_x is not eligible again until the next cycle.
    always_comb begin
        grant_d = 1'b0;
        grant_i = 1'b0;
        case (state)
            IDLE: begin
                grant_d = bus.d_req;
                grant_i = ~bus.d_req & bus.if_req;
            end
            RESP_I:  grant_d = bus.d_req;
            RESP_D:  grant_i = bus.if_req;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            m_req_q    <= 1'b0;
            m_we_q     <= 1'b0;
            m_size_q   <= 3'b000;
            m_addr_q   <= '0;
            m_wdata_q  <= '0;
            if_ack_q   <= 1'b0;
            d_ack_q    <= 1'b0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
            busy_q     <= 32'd0;
        end else begin
            if_ack_q <= 1'b0;
            d_ack_q  <= 1'b0;
            if (state != IDLE) busy_q <= busy_q + 32'd1;

            if (grant_d) begin
                state     <= BUSY_D;
                m_req_q   <= 1'b1;
                m_we_q    <= bus.d_we;
                m_size_q  <= bus.d_size;
                m_addr_q  <= bus.d_addr;
                m_wdata_q <= bus.d_wdata;
            end else if (grant_i) begin
                state     <= BUSY_I;
                m_req_q   <= 1'b1;
                m_we_q    <= 1'b0;
                m_size_q  <= 3'b010;
                m_addr_q  <= bus.if_addr;
                m_wdata_q <= '0;
            end else begin
                case (state)
                    BUSY_I: if (bus.m_ack) begin
                        if_rdata_q <= bus.m_rdata;
                        if_ack_q   <= 1'b1;
                        m_req_q    <= 1'b0;
                        state      <= RESP_I;
                    end
                    BUSY_D: if (bus.m_ack) begin
                        if (!m_we_q) d_rdata_q <= bus.m_rdata;
                        d_ack_q <= 1'b1;
                        m_req_q <= 1'b0;
                        state   <= RESP_D;
                    end
                    RESP_I, RESP_D: state <= IDLE;
                    default: ;
                endcase
            end
        end
    end

    assign bus.m_req       = m_req_q;
    assign bus.m_we        = m_we_q;
    assign bus.m_size      = m_size_q;
    assign bus.m_addr      = m_addr_q;
    assign bus.m_wdata     = m_wdata_q;
    assign bus.if_ack      = if_ack_q;
    assign bus.d_ack       = d_ack_q;
    assign bus.if_rdata    = if_rdata_q;
    assign bus.d_rdata     = d_rdata_q;
    assign bus.busy_cycles = busy_q;
    assign bus.stall       = (bus.if_req & ~if_ack_q) | (bus.d_req & ~d_ack_q);
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: vector table of isolated transactions plus hand-written multi-cycle sequences.
module tb_mem_arbiter;
    logic clk;
    logic reset;

    mem_arbiter_if #(.AW(32), .DW(32)) bus ();

    mem_arbiter #(.AW(32), .DW(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        is_d;
        logic        we;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          lat;
        logic [31:0] rdata;
    } vec_t;

    int   checks = 0;
    int   failures = 0;
    vec_t grant_q[$];
    vec_t ack_q[$];
    vec_t cur;
    int   cyc = 0;
    int   mem_lat = 1;
    int   mem_cnt = 0;
    bit   mem_auto = 1'b1;
    bit   hold_d = 1'b0;
    bit   prev_mreq = 1'b0;
    int   ack_cyc_d = 0;
    int   grant_cyc = 0;
    logic stall_at_ack = 1'b0;

    function automatic logic [31:0] mem_val(input logic [31:0] a);
        if (a == 32'h40)  return 32'h0050_0093;
        if (a == 32'h200) return 32'hDEAD_BEEF;
        return {a[15:0] ^ 16'h5A5A, a[15:0]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock: monitor acks/grants against the scoreboard, then play the memory.
    task automatic tick();
        vec_t e;
        @(posedge clk);
        #1;
        cyc++;
        if (bus.if_ack || bus.d_ack) begin
            stall_at_ack = bus.stall;
            if (ack_q.size() == 0) begin
                chk("spurious_ack", 32'(bus.if_ack | bus.d_ack), 32'd0);
            end else begin
                e = ack_q.pop_front();
                chk("ack_is_data", 32'(bus.d_ack), 32'(e.is_d));
                chk("single_ack", 32'(bus.if_ack & bus.d_ack), 32'd0);
                chk(e.is_d ? "d_rdata" : "if_rdata", e.is_d ? bus.d_rdata : bus.if_rdata, e.rdata);
            end
            if (bus.d_ack) begin
                ack_cyc_d = cyc;
                if (!hold_d) bus.d_req = 1'b0;
            end
            if (bus.if_ack) bus.if_req = 1'b0;
        end
        if (bus.m_req && !prev_mreq) begin
            grant_cyc = cyc;
            mem_cnt = 0;
            if (grant_q.size() == 0) begin
                chk("spurious_grant", 32'(bus.m_req), 32'd0);
            end else begin
                cur = grant_q.pop_front();
                chk("m_we", 32'(bus.m_we), 32'(cur.we));
                chk("m_size", 32'(bus.m_size), 32'(cur.size));
                chk("m_addr", bus.m_addr, cur.addr);
                chk("m_wdata", bus.m_wdata, cur.wdata);
            end
        end else if (bus.m_req) begin
            chk("m_stable", 32'({bus.m_we, bus.m_size, bus.m_addr, bus.m_wdata}
                               != {cur.we, cur.size, cur.addr, cur.wdata}), 32'd0);
        end
        prev_mreq = bus.m_req;
        bus.m_ack = 1'b0;
        bus.m_rdata = $urandom;
        if (bus.m_req && mem_auto) begin
            mem_cnt++;
            if (mem_cnt >= mem_lat) begin
                bus.m_ack = 1'b1;
                bus.m_rdata = mem_val(bus.m_addr);
            end
        end
    endtask

    task automatic issue(input vec_t v);
        vec_t g;
        g = v;
        if (!v.is_d) begin
            g.we = 1'b0;
            g.size = 3'b010;
            g.wdata = 32'd0;
        end
        grant_q.push_back(g);
        ack_q.push_back(g);
        if (v.is_d) begin
            bus.d_req = 1'b1;
            bus.d_we = v.we;
            bus.d_size = v.size;
            bus.d_addr = v.addr;
            bus.d_wdata = v.wdata;
        end else begin
            bus.if_req = 1'b1;
            bus.if_addr = v.addr;
        end
    endtask

    task automatic run_until_idle(input int max);
        int n;
        n = 0;
        while ((ack_q.size() != 0 || bus.m_req) && n < max) begin
            tick();
            n++;
        end
        if (n >= max) chk("timeout", 32'(ack_q.size()), 32'd0);
    endtask

    function automatic vec_t mk(input logic is_d, input logic we, input logic [2:0] size,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input int lat, input logic [31:0] rdata);
        vec_t v;
        v.is_d = is_d; v.we = we; v.size = size; v.addr = addr;
        v.wdata = wdata; v.lat = lat; v.rdata = rdata;
        return v;
    endfunction

    vec_t vecs[6];

    initial begin
        int   b0;
        int   t0;
        int   first;
        bit   stall_lo;
        vec_t vd;
        vec_t vi;

        vecs[0] = mk(1'b0, 1'b0, 3'b010, 32'h40,   32'h0,         2, 32'h0050_0093);
        vecs[1] = mk(1'b1, 1'b0, 3'b010, 32'h200,  32'h0,         1, 32'hDEAD_BEEF);
        vecs[2] = mk(1'b1, 1'b1, 3'b000, 32'h301,  32'hAB,        3, 32'hDEAD_BEEF);
        vecs[3] = mk(1'b0, 1'b0, 3'b010, 32'h80,   32'h0,         1, mem_val(32'h80));
        vecs[4] = mk(1'b1, 1'b0, 3'b001, 32'h1004, 32'h0,         5, mem_val(32'h1004));
        vecs[5] = mk(1'b1, 1'b1, 3'b010, 32'h8,    32'h1234_5678, 2, mem_val(32'h1004));

        bus.if_req = 1'b0; bus.if_addr = '0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_size = 3'b000; bus.d_addr = '0; bus.d_wdata = '0;
        bus.m_rdata = '0; bus.m_ack = 1'b0;
        reset = 1'b1;

        #1;
        chk("rst_m_req", 32'(bus.m_req), 32'd0);
        chk("rst_m_addr", bus.m_addr, 32'd0);
        chk("rst_acks", 32'({bus.if_ack, bus.d_ack}), 32'd0);
        chk("rst_rdata", bus.if_rdata | bus.d_rdata, 32'd0);
        chk("rst_busy", bus.busy_cycles, 32'd0);
        chk("rst_stall_idle", 32'(bus.stall), 32'd0);
        bus.if_req = 1'b1;
        #1;
        chk("rst_stall_eq", 32'(bus.stall), 32'd1);
        bus.if_req = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        tick();
        tick();
        chk("idle_after_rst", 32'({bus.m_req, bus.stall}), 32'd0);

        // Isolated transactions from the vector table.
        foreach (vecs[i]) begin
            mem_lat = vecs[i].lat;
            b0 = int'(bus.busy_cycles);
            t0 = cyc;
            issue(vecs[i]);
            #1;
            chk("stall_on_req", 32'(bus.stall), 32'd1);
            stall_lo = 1'b0;
            for (int n = 0; n < 100 && ack_q.size() != 0; n++) begin
                tick();
                if (ack_q.size() != 0 && !bus.stall) stall_lo = 1'b1;
            end
            chk("ack_seen", 32'(ack_q.size()), 32'd0);
            chk("ack_latency", 32'(cyc - t0), 32'(vecs[i].lat + 1));
            chk("stall_at_ack", 32'(stall_at_ack), 32'd0);
            chk("stall_held", 32'(stall_lo), 32'd0);
            tick();
            chk("idle_after_ack", 32'({bus.m_req, bus.if_ack, bus.d_ack}), 32'd0);
            chk("busy_cycles", bus.busy_cycles, 32'(b0 + vecs[i].lat + 1));
        end

        // Simultaneous fetch and load: data first, fetch granted right after RESP_D.
        mem_lat = 1;
        vd = mk(1'b1, 1'b0, 3'b010, 32'h200, 32'h0, 1, 32'hDEAD_BEEF);
        vi = mk(1'b0, 1'b0, 3'b010, 32'h44,  32'h0, 1, mem_val(32'h44));
        issue(vd);
        issue(vi);
        run_until_idle(100);
        chk("b2b_no_gap", 32'(grant_cyc - ack_cyc_d), 32'd1);

        // Load re-requested by holding d_req: one IDLE cycle before the next m_req.
        vd = mk(1'b1, 1'b0, 3'b010, 32'h208, 32'h0, 1, mem_val(32'h208));
        hold_d = 1'b1;
        issue(vd);
        issue(vd);
        for (int n = 0; n < 50 && ack_q.size() > 1; n++) tick();
        first = ack_cyc_d;
        hold_d = 1'b0;
        run_until_idle(100);
        chk("rereq_gap", 32'(grant_cyc - first), 32'd2);
        tick();

        // m_ack while IDLE must be ignored.
        bus.m_ack = 1'b1;
        bus.m_rdata = 32'h0BAD_0BAD;
        tick();
        chk("spur_no_req", 32'(bus.m_req), 32'd0);
        chk("spur_no_ack", 32'({bus.if_ack, bus.d_ack}), 32'd0);
        chk("spur_if_rdata", bus.if_rdata, mem_val(32'h44));
        chk("spur_d_rdata", bus.d_rdata, mem_val(32'h208));
        tick();
        chk("spur_still_idle", 32'(bus.m_req), 32'd0);

        // Long wait in BUSY_I: 20 cycles with m_ack low.
        mem_lat = 21;
        issue(mk(1'b0, 1'b0, 3'b010, 32'h500, 32'h0, 21, mem_val(32'h500)));
        for (int n = 0; n < 10 && !bus.m_req; n++) tick();
        chk("long_m_req", 32'(bus.m_req), 32'd1);
        b0 = int'(bus.busy_cycles);
        stall_lo = 1'b0;
        for (int n = 0; n < 20; n++) begin
            tick();
            if (!bus.stall) stall_lo = 1'b1;
        end
        chk("long_stall", 32'(stall_lo), 32'd0);
        chk("long_busy20", bus.busy_cycles, 32'(b0 + 20));
        run_until_idle(100);
        tick();

        // Counter wrap.
        force dut.busy_q = 32'hFFFF_FFFE;
        #1;
        release dut.busy_q;
        mem_lat = 2;
        issue(mk(1'b0, 1'b0, 3'b010, 32'h600, 32'h0, 2, mem_val(32'h600)));
        tick();
        chk("wrap_start", bus.busy_cycles, 32'hFFFF_FFFE);
        tick();
        chk("wrap_ffffffff", bus.busy_cycles, 32'hFFFF_FFFF);
        tick();
        chk("wrap_zero", bus.busy_cycles, 32'h0);
        tick();
        chk("wrap_one", bus.busy_cycles, 32'h1);

        // Reset in the middle of a load: m_req drops without a clock, no ack afterwards.
        mem_auto = 1'b0;
        issue(mk(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 1, mem_val(32'h100)));
        for (int n = 0; n < 10 && !bus.m_req; n++) tick();
        tick();
        chk("mid_m_req", 32'(bus.m_req), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_m_req", 32'(bus.m_req), 32'd0);
        chk("mid_rst_busy", bus.busy_cycles, 32'd0);
        chk("mid_rst_m_addr", bus.m_addr, 32'd0);
        chk("mid_rst_stall_eq", 32'(bus.stall), 32'd1);
        bus.d_req = 1'b0;
        ack_q.delete();
        grant_q.delete();
        mem_auto = 1'b1;
        tick();
        reset = 1'b0;
        for (int n = 0; n < 4; n++) tick();
        chk("post_rst_idle", 32'({bus.m_req, bus.stall, bus.d_ack}), 32'd0);
        chk("post_rst_busy", bus.busy_cycles, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter that shares one variable-latency memory port between the core's instruction-fetch path and its load/store path. It sits between the single-cycle core (fetch port: PC/instr; data port: address, write data, write enable, access size, read data) and a unified memory with a req/ack handshake. It sequences one transaction at a time, gives data accesses priority over fetches, and raises a stall to freeze the core until its pending accesses complete.

## Interface
Parameters:
- AW, 32, address width
- DW, 32, data width

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- if_req  in  1  fetch request; held with if_addr stable until if_ack
- if_addr  in  AW  fetch address
- if_rdata  out  DW  fetched instruction, valid while if_ack=1
- if_ack  out  1  one-cycle fetch completion pulse
- d_req  in  1  data request; held with d_* stable until d_ack
- d_we  in  1  1 = store, 0 = load
- d_size  in  3  access size code, passed through unchanged
- d_addr  in  AW  data address
- d_wdata  in  DW  store data
- d_rdata  out  DW  load data, valid while d_ack=1 after a load
- d_ack  out  1  one-cycle data completion pulse
- m_req  out  1  memory request; stable with m_* until m_ack
- m_we  out  1  memory write enable
- m_size  out  3  memory access size
- m_addr  out  AW  memory address
- m_wdata  out  DW  memory write data
- m_rdata  in  DW  memory read data, valid with m_ack
- m_ack  in  1  one-cycle memory completion pulse; only meaningful while m_req=1
- stall  out  1  core freeze
- busy_cycles  out  32  count of cycles spent outside IDLE

## Operation
- States: IDLE, BUSY_I, BUSY_D, RESP_I, RESP_D.
- IDLE: if d_req, go to BUSY_D and register d_we/d_size/d_addr/d_wdata into m_*. Else if if_req, go to BUSY_I with m_we=0, m_size=3'b010, m_addr=if_addr, m_wdata=0. Else stay. m_req=1 in BUSY_x, 0 elsewhere.
- BUSY_x: hold all m_* stable. On m_ack, capture m_rdata (into if_rdata in BUSY_I; into d_rdata in BUSY_D only when m_we=0) and go to RESP_x.
- RESP_x: x_ack=1 for exactly this cycle. The acked requester is excluded from arbitration this cycle. If the other requester is asserting req, grant it directly (RESP_I with d_req -> BUSY_D; RESP_D with if_req -> BUSY_I) and load m_* as in IDLE. Otherwise go to IDLE.
- Priority: data over fetch whenever both are eligible in the same cycle.
- A requester that keeps req high after its ack is treated as issuing a new request. It is eligible from the cycle after RESP.
- if_rdata/d_rdata hold their last captured value outside ack cycles. Store acks leave d_rdata unchanged.
- stall = (if_req & ~if_ack) | (d_req & ~d_ack), combinational.
- busy_cycles increments by 1 every cycle state != IDLE and wraps 32'hFFFFFFFF -> 0.
- m_ack received outside BUSY_x is ignored.

## Timing
- Reset (async, immediate): state=IDLE. m_req, m_we, m_size, m_addr, m_wdata, if_ack, d_ack, if_rdata, d_rdata and busy_cycles are all 0. stall follows its equation.
- Reset mid-transaction abandons the memory access. m_req drops asynchronously, and no ack is issued for the abandoned request.
- Request sampled in IDLE at cycle t -> m_req=1 at t+1. m_ack at cycle t+k (k≥1) -> x_ack at t+k+1.
- Minimum isolated transaction: req at t, m_ack at t+1, ack at t+2, IDLE at t+3.
- Back-to-back, other requester waiting: its m_req rises in the cycle after RESP, with no IDLE gap.
- Same requester re-requesting: IDLE at RESP+1, m_req at RESP+2.
- m_* are registered outputs and change only on state entry into BUSY_x.

## Test plan
- Reset: assert reset mid-BUSY_D with m_addr=0x100 -> m_req=0 and busy_cycles=0 in the same cycle. After release with no requests -> state stays IDLE and stall=0.
- Isolated fetch: if_req, if_addr=0x40, memory acks 2 cycles after m_req with m_rdata=0x00500093 -> m_addr=0x40, m_we=0, m_size=3'b010. if_ack pulses 1 cycle with if_rdata=0x00500093. stall=1 until that ack cycle. busy_cycles=3.
- Simultaneous requests: if_req (0x44) and load d_req (d_addr=0x200, d_size=3'b010) in the same cycle -> data granted first, d_rdata=m_rdata=0xDEADBEEF, d_ack. Fetch of 0x44 goes out the cycle after RESP_D, with no IDLE cycle between.
- Store: d_req, d_we=1, d_size=3'b000, d_addr=0x301, d_wdata=0xAB -> m_we=1, m_size=3'b000, m_addr=0x301, m_wdata=0xAB. d_ack pulses; d_rdata keeps its prior value.
- Spurious m_ack: pulse m_ack while IDLE -> no state change and no ack. Hold m_ack=0 for 20 cycles in BUSY_I -> m_* stable throughout, stall=1, busy_cycles=20.
- Counter wrap: preload busy_cycles to 0xFFFFFFFE via a long run or force, then run 3 busy cycles -> value reads 0xFFFFFFFF, 0x0, 0x1.
